// File: rtl/bespoke_pkg.sv
// Shared constants and elaboration helpers for the inter-layer chunk buffer.
//   BYTE_W          : width of one signed element
//   chunks_per_vec  : chunks that make up one input vector
//   geometry_ok     : legality of the vector/chunk/depth parameter set
`timescale 1ns/1ps
package bespoke_pkg;

    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned chunks_per_vec(input int unsigned in_vec_length,
                                                   input int unsigned working_regs);
        return (working_regs == 0) ? 0 : in_vec_length / working_regs;
    endfunction

    // A vector must split into a whole, nonzero number of chunks and the
    // buffer must hold at least one vector.
    function automatic bit geometry_ok(input int unsigned in_vec_length,
                                       input int unsigned working_regs,
                                       input int unsigned depth_vecs);
        return (working_regs != 0) &&
               (in_vec_length >= working_regs) &&
               ((in_vec_length % working_regs) == 0) &&
               (depth_vecs >= 1);
    endfunction

endpackage

// File: rtl/vec_chunk_ram.sv
// Simple dual-port chunk storage: synchronous write, registered read with enable.
//   clk, rst          : clock, synchronous active-high reset (read register only)
//   wr_en/addr/data   : write port
//   rd_en/addr        : read request; rd_data updates on the next edge, holds otherwise
`timescale 1ns/1ps
module vec_chunk_ram #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 32,
    parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AddrW-1:0] wr_addr,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AddrW-1:0] rd_addr,
    output logic [Width-1:0] rd_data
);

    logic [Width-1:0] mem [Depth];

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register; a same-address write this edge returns the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/vec_chunk_fifo.sv
// Inter-layer chunk buffer: producer writes chunks, consumer reads them with
// one-cycle latency; in_data_ready signals that a whole vector is buffered.
//   clk_in, rst_in      : clock, synchronous active-high reset
//   wr_en, wr_data      : producer chunk write
//   rd_en               : consumer chunk request
//   rd_data, rd_valid   : read chunk and its strobe; rd_vec_last marks vector end
//   in_data_ready       : at least one full vector stored
//   full, empty, count  : occupancy
//   wr_overflow         : sticky, a write was dropped
//   rd_underflow        : sticky, a read was refused
`timescale 1ns/1ps
module vec_chunk_fifo
    import bespoke_pkg::*;
#(
    parameter int unsigned InVecLength = 16,
    parameter int unsigned WorkingRegs = 4,
    parameter int unsigned DepthVecs   = 2
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    input  logic                                     wr_en,
    input  logic signed [WorkingRegs-1:0][BYTE_W-1:0] wr_data,
    input  logic                                     rd_en,
    output logic signed [WorkingRegs-1:0][BYTE_W-1:0] rd_data,
    output logic                                     rd_valid,
    output logic                                     rd_vec_last,
    output logic                                     in_data_ready,
    output logic                                     full,
    output logic                                     empty,
    output logic [$clog2(chunks_per_vec(InVecLength, WorkingRegs)*DepthVecs+1)-1:0] count,
    output logic                                     wr_overflow,
    output logic                                     rd_underflow
);

    localparam int unsigned CPV    = chunks_per_vec(InVecLength, WorkingRegs);
    localparam int unsigned DEPTH  = DepthVecs * CPV;
    localparam int unsigned CW     = $clog2(DEPTH + 1);
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IW     = (CPV > 1) ? $clog2(CPV) : 1;
    localparam int unsigned DATA_W = WorkingRegs * BYTE_W;

    if (!geometry_ok(InVecLength, WorkingRegs, DepthVecs)) begin : g_bad_geometry
        $error("vec_chunk_fifo: InVecLength must be a nonzero multiple of WorkingRegs and DepthVecs >= 1");
    end

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic [CW-1:0]     count_next;
    logic              rd_accept;
    logic              wr_accept;
    logic [DATA_W-1:0] ram_rd_data;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (i == IW'(CPV - 1)) ? '0 : i + IW'(1);
    endfunction

    // No read bypass: an empty buffer refuses a read even with a write pending.
    // A full buffer still takes a write when a read frees a slot the same edge.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    // Occupancy after this edge.
    always_comb begin
        count_next = count;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    vec_chunk_ram #(
        .Depth (DEPTH),
        .Width (DATA_W),
        .AddrW (AW)
    ) u_ram (
        .clk     (clk_in),
        .rst     (rst_in),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (DATA_W'(wr_data)),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    assign rd_data = ram_rd_data;

    // Pointers, vector-boundary indices, occupancy flags and sticky errors.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            wr_idx        <= '0;
            rd_idx        <= '0;
            count         <= '0;
            rd_valid      <= 1'b0;
            rd_vec_last   <= 1'b0;
            in_data_ready <= 1'b0;
            full          <= 1'b0;
            empty         <= 1'b1;
            wr_overflow   <= 1'b0;
            rd_underflow  <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
                wr_idx <= idx_inc(wr_idx);
            end
            if (rd_accept) begin
                rd_ptr <= ptr_inc(rd_ptr);
                rd_idx <= idx_inc(rd_idx);
            end
            if (wr_en && !wr_accept) begin
                wr_overflow <= 1'b1;
            end
            if (rd_en && !rd_accept) begin
                rd_underflow <= 1'b1;
            end
            rd_valid      <= rd_accept;
            rd_vec_last   <= rd_accept && (rd_idx == IW'(CPV - 1));
            count         <= count_next;
            full          <= (count_next == CW'(DEPTH));
            empty         <= (count_next == '0);
            in_data_ready <= (count_next >= CW'(CPV));
        end
    end

endmodule

// File: tb/tb_vec_chunk_fifo.sv
// Self-checking bench for vec_chunk_fifo: queue-based reference model with a
// per-cycle compare process, directed scenarios with literal expectations,
// then randomized traffic with occasional resets.
`timescale 1ns/1ps
module tb_vec_chunk_fifo;

    localparam int unsigned IVL   = 16;
    localparam int unsigned WR    = 4;
    localparam int unsigned DV    = 2;
    localparam int unsigned CPV   = IVL / WR;
    localparam int unsigned DEPTH = DV * CPV;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic                         clk;
    logic                         rst;
    logic                         wr_en;
    logic signed [WR-1:0][7:0]    wr_data;
    logic                         rd_en;
    logic signed [WR-1:0][7:0]    rd_data;
    logic                         rd_valid;
    logic                         rd_vec_last;
    logic                         in_data_ready;
    logic                         full;
    logic                         empty;
    logic [CW-1:0]                count;
    logic                         wr_overflow;
    logic                         rd_underflow;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    vec_chunk_fifo #(
        .InVecLength (IVL),
        .WorkingRegs (WR),
        .DepthVecs   (DV)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_vec_last   (rd_vec_last),
        .in_data_ready (in_data_ready),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .wr_overflow   (wr_overflow),
        .rd_underflow  (rd_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of chunks plus a running read count.
    logic [31:0] q[$];
    logic [31:0] m_rd_data = '0;
    bit          m_rd_valid = 0;
    bit          m_last = 0;
    bit          m_ovf = 0;
    bit          m_udf = 0;
    int          m_reads = 0;

    always @(posedge clk) begin
        bit rd_ok;
        bit wr_ok;
        if (rst) begin
            q.delete();
            m_rd_data  = '0;
            m_rd_valid = 0;
            m_last     = 0;
            m_ovf      = 0;
            m_udf      = 0;
            m_reads    = 0;
        end else begin
            rd_ok = rd_en && (q.size() > 0);
            wr_ok = wr_en && ((q.size() < DEPTH) || rd_ok);
            m_rd_valid = rd_ok;
            m_last     = 0;
            if (rd_ok) begin
                m_rd_data = q.pop_front();
                m_last    = ((m_reads % CPV) == CPV - 1);
                m_reads++;
            end else if (rd_en) begin
                m_udf = 1;
            end
            if (wr_ok) q.push_back(32'(wr_data));
            else if (wr_en) m_ovf = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_data",       32'(rd_data),       m_rd_data);
            chk("rd_valid",      32'(rd_valid),      32'(m_rd_valid));
            chk("rd_vec_last",   32'(rd_vec_last),   32'(m_last));
            chk("count",         32'(count),         32'(q.size()));
            chk("full",          32'(full),          32'(q.size() == DEPTH));
            chk("empty",         32'(empty),         32'(q.size() == 0));
            chk("in_data_ready", 32'(in_data_ready), 32'(q.size() >= CPV));
            chk("wr_overflow",   32'(wr_overflow),   32'(m_ovf));
            chk("rd_underflow",  32'(rd_underflow),  32'(m_udf));
        end
    end

    function automatic logic [31:0] mk(input int k);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(4 * k + i);
        return v;
    endfunction

    task automatic cyc(input bit we, input logic [31:0] wd, input bit re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, '0, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; rd_en = 0; wr_data = '0;
        @(posedge clk); #1;
        chk_en = 1;
        cyc(0, '0, 0);
        rst = 1'b0;
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset count", 32'(count), 32'd0);

        // One vector in, then streamed out.
        for (int k = 0; k < 4; k++) begin
            cyc(1, mk(k), 0);
            if (k == 2) chk("ready before 4th", 32'(in_data_ready), 32'd0);
        end
        chk("ready after 4th", 32'(in_data_ready), 32'd1);
        chk("count after 4",   32'(count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            cyc(0, '0, 1);
            chk("stream valid", 32'(rd_valid), 32'd1);
            chk("stream last",  32'(rd_vec_last), 32'(k == 3));
            if (k == 0) chk("c0 literal", 32'(rd_data), 32'h03020100);
            if (k == 3) chk("c3 literal", 32'(rd_data), 32'h0F0E0D0C);
        end
        cyc(0, '0, 0);
        chk("empty after stream", 32'(empty), 32'd1);
        chk("rd_data holds", 32'(rd_data), 32'h0F0E0D0C);

        // Fill, overflow, drain.
        for (int k = 10; k < 18; k++) cyc(1, mk(k), 0);
        chk("full at 8", 32'(full), 32'd1);
        chk("count 8",   32'(count), 32'd8);
        cyc(1, mk(99), 0);
        chk("overflow set",   32'(wr_overflow), 32'd1);
        chk("count still 8",  32'(count), 32'd8);
        for (int k = 0; k < 8; k++) cyc(0, '0, 1);
        chk("drain last", 32'(rd_data), mk(17));
        do_reset();

        // Full with simultaneous read/write across the pointer wrap.
        for (int k = 40; k < 48; k++) cyc(1, mk(k), 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, mk(50 + k), 1);
            chk("rw full data",  32'(rd_data), mk(40 + k));
            chk("rw full count", 32'(count), 32'd8);
            chk("rw no ovf",     32'(wr_overflow), 32'd0);
        end
        for (int k = 0; k < 8; k++) cyc(0, '0, 1);
        chk("wrap tail", 32'(rd_data), mk(52));

        // Empty buffer: read refused, write still lands.
        cyc(1, mk(30), 1);
        chk("empty rw valid", 32'(rd_valid), 32'd0);
        chk("empty rw udf",   32'(rd_underflow), 32'd1);
        chk("empty rw count", 32'(count), 32'd1);
        cyc(0, '0, 1);
        chk("late read", 32'(rd_data), mk(30));

        // Sign-extreme bytes survive bit-exact.
        cyc(1, 32'h7F00FF80, 0);
        cyc(0, '0, 1);
        chk("neg chunk", 32'(rd_data), 32'h7F00FF80);
        chk("neg elem0", 32'($signed(rd_data[0])), 32'hFFFFFF80);

        // Reset mid-stream.
        for (int k = 60; k < 65; k++) cyc(1, mk(k), 0);
        chk("count 5", 32'(count), 32'd5);
        do_reset();
        chk("rst count", 32'(count), 32'd0);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst ready", 32'(in_data_ready), 32'd0);
        chk("rst valid", 32'(rd_valid), 32'd0);
        for (int k = 70; k < 74; k++) cyc(1, mk(k), 0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, '0, 1);
            chk("fresh last", 32'(rd_vec_last), 32'(k == 3));
        end

        // Randomized traffic in write-heavy, read-heavy and balanced phases.
        for (int i = 0; i < 2400; i++) begin
            int ph;
            int wp;
            int rp;
            ph = (i / 300) % 3;
            wp = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
            rp = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
            rst = ($urandom_range(0, 249) == 0);
            cyc($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp);
        end
        rst = 1'b0;
        cyc(0, '0, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_chunk_fifo.md
Name: vec_chunk_fifo

Overview:
- Inter-layer chunk buffer that feeds a layer's chunk-request input port from the previous layer's chunk-write output port.
- Accepts chunks of WorkingRegs signed bytes from the producer and serves them to the consumer with single-cycle read latency.
- Tracks vector boundaries and raises in_data_ready only when at least one complete InVecLength vector is buffered.
- Consumers may therefore stream a whole vector without stalling.

Parameters:
- InVecLength, 16, elements per vector; must be a multiple of WorkingRegs.
- WorkingRegs, 4, signed 8-bit elements per chunk.
- DepthVecs, 2, whole vectors of storage, at least 1.
- Derived: CPV = InVecLength/WorkingRegs chunks per vector; DEPTH = DepthVecs*CPV chunks; CW = $clog2(DEPTH+1).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- wr_en  in  1  producer chunk-write strobe (driven by producer's req_chunk_out)
- wr_data  in  [WorkingRegs-1:0][7:0] signed  chunk to write
- rd_en  in  1  consumer chunk request (driven by consumer's req_chunk_in)
- rd_data  out  [WorkingRegs-1:0][7:0] signed  chunk read out; registered
- rd_valid  out  1  rd_data updated this cycle
- rd_vec_last  out  1  qualifies rd_valid: last chunk of a vector
- in_data_ready  out  1  count >= CPV
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  CW  chunks stored
- wr_overflow  out  1  sticky: write dropped
- rd_underflow  out  1  sticky: read refused

Behaviour:
- Reset values: all pointers 0, count 0, rd_data 0, rd_valid 0, rd_vec_last 0, in_data_ready 0, full 0, empty 1, both sticky flags 0. Write chunk index and read chunk index are both 0.
- Reset mid-operation discards all buffered data. Storage contents need not be cleared.
- Circular buffer of DEPTH chunks. Write and read pointers wrap from DEPTH-1 to 0.
- Write acceptance:
  - Write accepted when wr_en && (!full || read accepted in the same cycle).
  - An accepted write stores the chunk and advances the write pointer.
  - A write that is not accepted is dropped and sets wr_overflow.
- Read acceptance:
  - Read accepted when rd_en && !empty. There is no same-cycle bypass, so a read on an empty buffer is refused even if a write arrives that cycle.
  - Accepted read: on the next edge rd_data takes mem[rd_ptr] and rd_valid=1 for one cycle; the read pointer advances.
  - Refused read: rd_valid=0, rd_data holds its value, rd_underflow is set.
- rd_data holds its last value whenever rd_valid=0. Latency from accepted rd_en to rd_valid is exactly 1 cycle.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- full, empty and in_data_ready are registered and consistent with the post-edge count.
- Vector boundaries:
  - The write chunk index counts 0..CPV-1 on accepted writes and wraps.
  - The read chunk index counts 0..CPV-1 on accepted reads and wraps.
  - rd_vec_last=1 with rd_valid when the chunk read had read index CPV-1.
- Simultaneous read and write when full: both accepted, count stays DEPTH, no overflow.
- Sticky flags clear only on rst_in.
- No state machine beyond the pointers and counters. Every output is a flop.

Decomposition:
- Shared package bespoke_pkg:
  - constant BYTE_W = 8;
  - function chunks_per_vec(InVecLength, WorkingRegs);
  - function elaboration checks for divisibility and DepthVecs >= 1, failing with $error.
- One sub-module, vec_chunk_ram: DEPTH x (WorkingRegs*8) simple dual-port register array, synchronous write, registered synchronous read with read enable.
- vec_chunk_fifo owns pointers, count, flags and boundary tracking.

Test Plan (defaults: CPV=4, DEPTH=8):
- Reset then write 4 chunks {c0..c3}, where chunk k has element i equal to 4k+i:
  - in_data_ready rises the cycle after the 4th write; count=4.
  - Then hold rd_en for 4 cycles: rd_data is c0..c3 on consecutive cycles with 1-cycle latency, rd_vec_last only with c3, and empty=1 afterwards.
- Write 8 chunks: full=1, count=8.
  - A 9th write with rd_en=0 is dropped: wr_overflow=1, count stays 8.
  - Reading out returns the first 8 chunks in order.
- Full buffer, wr_en=1 and rd_en=1 for 3 cycles: count stays 8, no overflow, output order preserved across pointer wrap.
- Empty buffer, rd_en=1 and wr_en=1 in the same cycle: read refused (rd_valid=0, rd_underflow=1), write stored, count=1. A read on the next cycle returns that chunk.
- Negative data (-128, -1, 0, 127) written and read back bit-exact, with sign preserved.
- Assert rst_in with count=5 mid-stream: next cycle count=0, empty=1, in_data_ready=0, rd_valid=0. A fresh 4-chunk vector then reads back with rd_vec_last on the 4th chunk.
